tlc_monitor: RTL and testbench
==============================

Name: tlc_monitor

Overview:
- Passive observer at the output end of the traffic light controller interface.
- Samples the NS/EW LED codes, pedestrian allow and pedestrian request, and decodes them into a phase.
- Checks encoding, phase-sequence legality and per-phase dwell time against the controller timing parameters.
- Reports violations through sticky fault, one-cycle fault pulse, code and counters, for top-level safety logic and for bench use.

Parameters:
GREEN_TIME, 10, controller green load value; legal green dwell = GREEN_TIME+1 cycles
YELLOW_TIME, 5, yellow load value; legal yellow dwell = YELLOW_TIME+1 cycles
PED_TIME, 15, pedestrian load value; legal pedestrian dwell = PED_TIME+1 cycles
CNT_W, 8, width of the dwell, violation and cycle counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
ns_leds  in  3  NS lamp code: 100 red, 010 yellow, 001 green
ew_leds  in  3  EW lamp code, same encoding
ped_allow  in  1  pedestrian walk indication
ped_req  in  1  pedestrian button, as seen by the controller
fault_clr  in  1  clears sticky fault (synchronous)
phase  out  3  decoded phase: 0 NS_G, 1 NS_Y, 2 EW_G, 3 EW_Y, 4 PED, 7 ILLEGAL
fault  out  1  sticky fault flag
fault_pulse  out  1  one-cycle strobe per detected violation
fault_code  out  3  code of most recent violation
viol_cnt  out  CNT_W  violations seen, saturating
cycle_cnt  out  CNT_W  completed signal cycles, wrapping

Behaviour:
- Reset values: phase=7, fault=0, fault_pulse=0, fault_code=0, viol_cnt=0, cycle_cnt=0; FSM in SYNC; ped_pending=0.
- Reset is asserted asynchronously, released synchronously to clk (the release synchroniser is external).
- Reset mid-operation discards all history and re-enters SYNC.
- Decode is combinational on the inputs. All outputs are registered, so every output reflects the inputs sampled 1 cycle earlier.
- Decode table (each entry has ped_allow=0 unless stated):
  - 001/100 -> NS_G
  - 010/100 -> NS_Y
  - 100/001 -> EW_G
  - 100/010 -> EW_Y
  - 100/100 with ped_allow=1 -> PED
  - 100/100 with ped_allow=0 -> ILLEGAL
  - any non-one-hot code, both directions non-red, or ped_allow=1 with any non-red -> ILLEGAL
- Fault codes:
  - 1 ILLEGAL decode
  - 2 illegal transition
  - 3 dwell short
  - 4 dwell long
  - 5 PED entered without a pending request
- Legal transitions: NS_G->NS_Y, NS_Y->EW_G, EW_G->EW_Y, EW_Y->NS_G, EW_Y->PED, PED->NS_G.
- FSM states:
  - SYNC: no dwell checks; leaves on the first change between two legal phases, after which the dwell counter starts at 1.
  - TRACK: all checks active.
  - ILLEGAL decode is checked in both states.
- Dwell counter:
  - Counts consecutive cycles of the same sampled phase and saturates at all-ones.
  - On a phase change in TRACK: previous dwell < expected -> code 3; legality checked -> code 2.
  - Code 4 fires once, in the cycle the dwell reaches expected+1 while the phase is unchanged.
- ILLEGAL handling: code 1 fires each cycle ILLEGAL is sampled. On return to a legal phase the FSM goes to SYNC.
- ped_pending:
  - Set when ped_req=1 is sampled.
  - Cleared on entry to PED.
  - Entry to PED with ped_pending=0 -> code 5.
  - If a set and a clear occur in the same cycle, the clear wins.
- Simultaneous violations in one cycle: one pulse, viol_cnt +1, fault_code = lowest code number.
- fault sets with fault_pulse. fault_clr clears fault, but a violation in the same cycle wins and fault stays 1. fault_code and counters are unaffected by fault_clr.
- viol_cnt saturates at 2^CNT_W-1.
- cycle_cnt increments on each EW_Y->NS_G or PED->NS_G transition in TRACK; it wraps.

Decomposition:
- Shared package tlc_pkg:
  - lamp encodings RED/YELLOW/GREEN
  - phase_t enum (values above)
  - fault_code_t enum
  - timing parameter defaults, shared with the controller
- Sub-module tlc_phase_decode: combinational LED/ped_allow -> phase_t. It is reused by the bench scoreboard.

Test Plan:
- Drive a legal cycle (NS_G 11, NS_Y 6, EW_G 11, EW_Y 6 cycles) twice after SYNC -> fault=0, viol_cnt=0, cycle_cnt=2.
- Assert ped_req for 1 cycle during EW_G, then EW_Y->PED for 16 cycles ->NS_G -> no fault, cycle_cnt +1.
- Drive NS_G=001 and EW=001 for 1 cycle -> phase=7, fault_pulse=1, fault_code=1, viol_cnt=1; fault stays 1 until fault_clr.
- In TRACK, hold NS_Y 4 cycles then EW_G -> code 3. Separately, NS_G->EW_G -> code 2.
- Hold EW_G 20 cycles -> exactly one pulse, code 4, at dwell 12. Separately, enter PED with no request -> code 5.
- Force 300 violations -> viol_cnt=255. Assert reset mid-phase -> all outputs return to reset values and the FSM re-enters SYNC.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller and its output monitor.
package tlc_pkg;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam int unsigned GREEN_TIME_DEF  = 10;
  localparam int unsigned YELLOW_TIME_DEF = 5;
  localparam int unsigned PED_TIME_DEF    = 15;
  localparam int unsigned CNT_W_DEF       = 8;

  typedef enum logic [2:0] {
    PH_NS_G    = 3'd0,
    PH_NS_Y    = 3'd1,
    PH_EW_G    = 3'd2,
    PH_EW_Y    = 3'd3,
    PH_PED     = 3'd4,
    PH_ILLEGAL = 3'd7
  } phase_t;

  typedef enum logic [2:0] {
    FC_NONE    = 3'd0,
    FC_ILLEGAL = 3'd1,
    FC_TRANS   = 3'd2,
    FC_SHORT   = 3'd3,
    FC_LONG    = 3'd4,
    FC_NO_REQ  = 3'd5
  } fault_code_t;

  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_TRACK = 1'b1
  } mon_state_t;

  // Phase successor table of the controller.
  function automatic logic legal_transition(input phase_t from_ph, input phase_t to_ph);
    logic ok;
    ok = 1'b0;
    case (from_ph)
      PH_NS_G: ok = (to_ph == PH_NS_Y);
      PH_NS_Y: ok = (to_ph == PH_EW_G);
      PH_EW_G: ok = (to_ph == PH_EW_Y);
      PH_EW_Y: ok = (to_ph == PH_NS_G) || (to_ph == PH_PED);
      PH_PED:  ok = (to_ph == PH_NS_G);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/tlc_monitor_if.sv
// Lamp/pedestrian bundle at the controller output; the controller drives it, monitors observe it.
interface tlc_monitor_if;
  logic [2:0] ns_leds;
  logic [2:0] ew_leds;
  logic       ped_allow;
  logic       ped_req;

  modport master (output ns_leds, output ew_leds, output ped_allow, output ped_req);
  modport slave  (input  ns_leds, input  ew_leds, input  ped_allow, input  ped_req);
endinterface

// File: rtl/tlc_phase_decode.sv
// Combinational decode of lamp codes and walk indication into a controller phase.
module tlc_phase_decode
  import tlc_pkg::*;
(
  input  logic [2:0] ns_leds,
  input  logic [2:0] ew_leds,
  input  logic       ped_allow,
  output phase_t     phase
);

  // Only the five exact lamp patterns are legal; everything else is ILLEGAL.
  always_comb begin
    phase = PH_ILLEGAL;
    case ({ns_leds, ew_leds})
      {LAMP_GREEN,  LAMP_RED}:    if (!ped_allow) phase = PH_NS_G;
      {LAMP_YELLOW, LAMP_RED}:    if (!ped_allow) phase = PH_NS_Y;
      {LAMP_RED,    LAMP_GREEN}:  if (!ped_allow) phase = PH_EW_G;
      {LAMP_RED,    LAMP_YELLOW}: if (!ped_allow) phase = PH_EW_Y;
      {LAMP_RED,    LAMP_RED}:    if (ped_allow)  phase = PH_PED;
      default:                    phase = PH_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/tlc_monitor.sv
// Passive checker for the traffic light controller output: encoding, sequence and dwell time.
module tlc_monitor
  import tlc_pkg::*;
#(
  parameter int unsigned GREEN_TIME  = GREEN_TIME_DEF,
  parameter int unsigned YELLOW_TIME = YELLOW_TIME_DEF,
  parameter int unsigned PED_TIME    = PED_TIME_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  tlc_monitor_if.slave     bus,
  input  logic             fault_clr,
  output logic [2:0]       phase,
  output logic             fault,
  output logic             fault_pulse,
  output logic [2:0]       fault_code,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  phase_t           cur_ph;
  mon_state_t       state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             fault_q, fault_d;
  logic             fault_pulse_q, fault_pulse_d;
  fault_code_t      fault_code_q, fault_code_d;
  logic             ped_pending_q, ped_pending_d;

  logic             cur_legal, prev_legal, changed, legal_change, ped_entry;
  logic [CNT_W-1:0] dwell_exp, dwell_inc;
  logic             v_illegal, v_trans, v_short, v_long, v_noreq, any_viol;

  tlc_phase_decode u_decode (
    .ns_leds   (bus.ns_leds),
    .ew_leds   (bus.ew_leds),
    .ped_allow (bus.ped_allow),
    .phase     (cur_ph)
  );

  // Expected dwell of the phase currently being timed.
  always_comb begin
    dwell_exp = '1;
    case (phase_q)
      PH_NS_G, PH_EW_G: dwell_exp = CNT_W'(GREEN_TIME + 1);
      PH_NS_Y, PH_EW_Y: dwell_exp = CNT_W'(YELLOW_TIME + 1);
      PH_PED:           dwell_exp = CNT_W'(PED_TIME + 1);
      default:          dwell_exp = '1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_SYNC;
    else        state_q <= state_d;
  end

  // Next state: lock on at the first legal-to-legal change, fall back whenever ILLEGAL is seen.
  // Leaving TRACK already on ILLEGAL entry is equivalent to leaving on the return to a legal
  // phase, since no legal-change check can fire while ILLEGAL is being sampled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC:  if (legal_change) state_d = ST_TRACK;
      ST_TRACK: if (!cur_legal)   state_d = ST_SYNC;
      default:  state_d = ST_SYNC;
    endcase
  end

  // Violation detection and next values of all tracked outputs.
  always_comb begin
    cur_legal    = (cur_ph != PH_ILLEGAL);
    prev_legal   = (phase_q != PH_ILLEGAL);
    changed      = (cur_ph != phase_q);
    legal_change = changed && cur_legal && prev_legal;
    ped_entry    = (cur_ph == PH_PED) && (phase_q != PH_PED);
    dwell_inc    = (dwell_q == '1) ? dwell_q : dwell_q + CNT_W'(1);

    v_illegal = !cur_legal;
    v_trans   = (state_q == ST_TRACK) && legal_change && !legal_transition(phase_q, cur_ph);
    v_short   = (state_q == ST_TRACK) && legal_change && (dwell_q < dwell_exp);
    v_long    = (state_q == ST_TRACK) && !changed && cur_legal &&
                (dwell_q == dwell_exp) && (dwell_q != '1);
    v_noreq   = ped_entry && !ped_pending_q;
    any_viol  = v_illegal || v_trans || v_short || v_long || v_noreq;

    phase_d       = cur_ph;
    dwell_d       = changed ? CNT_W'(1) : dwell_inc;
    fault_pulse_d = any_viol;
    fault_d       = any_viol ? 1'b1 : (fault_clr ? 1'b0 : fault_q);

    fault_code_d = fault_code_q;
    if      (v_illegal) fault_code_d = FC_ILLEGAL;
    else if (v_trans)   fault_code_d = FC_TRANS;
    else if (v_short)   fault_code_d = FC_SHORT;
    else if (v_long)    fault_code_d = FC_LONG;
    else if (v_noreq)   fault_code_d = FC_NO_REQ;

    viol_cnt_d = viol_cnt_q;
    if (any_viol && (viol_cnt_q != '1)) viol_cnt_d = viol_cnt_q + CNT_W'(1);

    cycle_cnt_d = cycle_cnt_q;
    if ((state_q == ST_TRACK) && legal_change && (cur_ph == PH_NS_G) &&
        ((phase_q == PH_EW_Y) || (phase_q == PH_PED)))
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);

    ped_pending_d = ped_entry ? 1'b0 : (bus.ped_req ? 1'b1 : ped_pending_q);
  end

  // Registered outputs and history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q       <= PH_ILLEGAL;
      dwell_q       <= '0;
      viol_cnt_q    <= '0;
      cycle_cnt_q   <= '0;
      fault_q       <= 1'b0;
      fault_pulse_q <= 1'b0;
      fault_code_q  <= FC_NONE;
      ped_pending_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      dwell_q       <= dwell_d;
      viol_cnt_q    <= viol_cnt_d;
      cycle_cnt_q   <= cycle_cnt_d;
      fault_q       <= fault_d;
      fault_pulse_q <= fault_pulse_d;
      fault_code_q  <= fault_code_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  assign phase       = phase_q;
  assign fault       = fault_q;
  assign fault_pulse = fault_pulse_q;
  assign fault_code  = fault_code_q;
  assign viol_cnt    = viol_cnt_q;
  assign cycle_cnt   = cycle_cnt_q;

endmodule

// File: tb/tb_tlc_monitor.sv
// Directed bench for tlc_monitor with hand-computed expectations.
module tb_tlc_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fault_clr = 1'b0;
  logic [2:0] phase;
  logic       fault;
  logic       fault_pulse;
  logic [2:0] fault_code;
  logic [7:0] viol_cnt;
  logic [7:0] cycle_cnt;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  int p0 = 0;

  tlc_monitor_if bus_if ();

  tlc_monitor #(
    .GREEN_TIME  (10),
    .YELLOW_TIME (5),
    .PED_TIME    (15),
    .CNT_W       (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .fault_clr   (fault_clr),
    .phase       (phase),
    .fault       (fault),
    .fault_pulse (fault_pulse),
    .fault_code  (fault_code),
    .viol_cnt    (viol_cnt),
    .cycle_cnt   (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // 0 NS_G, 1 NS_Y, 2 EW_G, 3 EW_Y, 4 PED, 5 both green (illegal)
  task automatic drive(input int p, input logic req);
    bus_if.ped_allow = 1'b0;
    case (p)
      0: begin bus_if.ns_leds = 3'b001; bus_if.ew_leds = 3'b100; end
      1: begin bus_if.ns_leds = 3'b010; bus_if.ew_leds = 3'b100; end
      2: begin bus_if.ns_leds = 3'b100; bus_if.ew_leds = 3'b001; end
      3: begin bus_if.ns_leds = 3'b100; bus_if.ew_leds = 3'b010; end
      4: begin bus_if.ns_leds = 3'b100; bus_if.ew_leds = 3'b100; bus_if.ped_allow = 1'b1; end
      default: begin bus_if.ns_leds = 3'b001; bus_if.ew_leds = 3'b001; end
    endcase
    bus_if.ped_req = req;
  endtask

  task automatic hold(input int p, input int n, input logic req = 1'b0, input logic clr = 1'b0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(p, req);
      fault_clr = clr;
      @(posedge clk);
      #1;
      if (fault_pulse) pulses++;
    end
  endtask

  initial begin
    drive(0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_phase", phase, 7);
    chk("rst_fault", fault, 0);
    chk("rst_pulse", fault_pulse, 0);
    chk("rst_code", fault_code, 0);
    chk("rst_viol", viol_cnt, 0);
    chk("rst_cycle", cycle_cnt, 0);
    @(negedge clk);
    reset = 1'b1;

    // SYNC, then two full legal cycles
    hold(0, 5);
    chk("sync_phase", phase, 0);
    hold(1, 6); hold(2, 11); hold(3, 6); hold(0, 11);
    hold(1, 6); hold(2, 11); hold(3, 6); hold(0, 1);
    chk("legal_cycle", cycle_cnt, 2);
    chk("legal_fault", fault, 0);
    chk("legal_viol", viol_cnt, 0);
    chk("legal_pulses", pulses, 0);

    // requested pedestrian phase
    hold(0, 10); hold(1, 6); hold(2, 1, 1'b1); hold(2, 10); hold(3, 6); hold(4, 1);
    chk("ped_phase", phase, 4);
    chk("ped_pulse", fault_pulse, 0);
    hold(4, 15); hold(0, 1);
    chk("ped_cycle", cycle_cnt, 3);
    chk("ped_viol", viol_cnt, 0);

    // illegal lamp code, sticky fault, clear
    hold(0, 10); hold(5, 1);
    chk("ill_phase", phase, 7);
    chk("ill_pulse", fault_pulse, 1);
    chk("ill_code", fault_code, 1);
    chk("ill_viol", viol_cnt, 1);
    chk("ill_fault", fault, 1);
    hold(1, 3);
    chk("sticky_fault", fault, 1);
    chk("sticky_pulse", fault_pulse, 0);
    hold(1, 1, 1'b0, 1'b1);
    chk("clr_fault", fault, 0);
    chk("clr_code", fault_code, 1);
    chk("clr_viol", viol_cnt, 1);

    // back to TRACK, then short yellow
    hold(1, 2); hold(2, 1);
    chk("resync_fault", fault, 0);
    hold(2, 10); hold(3, 6); hold(0, 11);
    chk("resync_cycle", cycle_cnt, 4);
    hold(1, 4); hold(2, 1);
    chk("short_pulse", fault_pulse, 1);
    chk("short_code", fault_code, 3);
    chk("short_viol", viol_cnt, 2);

    // NS_G -> EW_G
    hold(2, 10); hold(3, 6); hold(0, 11); hold(2, 1);
    chk("trans_pulse", fault_pulse, 1);
    chk("trans_code", fault_code, 2);
    chk("trans_viol", viol_cnt, 3);
    chk("trans_cycle", cycle_cnt, 5);

    // overlong green: one pulse at dwell 12
    p0 = pulses;
    hold(2, 10);
    chk("long_early", pulses - p0, 0);
    hold(2, 1);
    chk("long_pulse", fault_pulse, 1);
    chk("long_code", fault_code, 4);
    chk("long_viol", viol_cnt, 4);
    hold(2, 8);
    chk("long_once", pulses - p0, 1);

    // PED without request
    hold(3, 6); hold(4, 1);
    chk("noreq_pulse", fault_pulse, 1);
    chk("noreq_code", fault_code, 5);
    chk("noreq_viol", viol_cnt, 5);
    hold(4, 15); hold(0, 1);
    chk("noreq_cycle", cycle_cnt, 6);

    // short yellow plus unrequested PED, with fault_clr in the same cycle
    hold(0, 10); hold(1, 6); hold(2, 11); hold(3, 1, 1'b0, 1'b1);
    chk("pre_clr_fault", fault, 0);
    hold(3, 1); hold(4, 1, 1'b0, 1'b1);
    chk("multi_code", fault_code, 3);
    chk("multi_viol", viol_cnt, 6);
    chk("multi_fault", fault, 1);
    chk("multi_pulse", fault_pulse, 1);

    // saturation of the violation counter
    hold(5, 300);
    chk("sat_viol", viol_cnt, 255);
    chk("sat_code", fault_code, 1);
    hold(5, 1);
    chk("sat_hold", viol_cnt, 255);

    // asynchronous reset mid-phase
    hold(0, 3);
    #2 reset = 1'b0;
    #1;
    chk("arst_phase", phase, 7);
    chk("arst_fault", fault, 0);
    chk("arst_pulse", fault_pulse, 0);
    chk("arst_code", fault_code, 0);
    chk("arst_viol", viol_cnt, 0);
    chk("arst_cycle", cycle_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    hold(0, 3); hold(1, 1);
    chk("arst_sync_phase", phase, 1);
    chk("arst_sync_pulse", fault_pulse, 0);
    chk("arst_sync_fault", fault, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
